// File: rtl/midi_msg_parser.sv
// MIDI byte-stream decoder: turns raw UART bytes into Note On / Note Off events.
// Define MIDI_VEL0_NOTEOFF_EN to report Note On with velocity 0 as Note Off.
module midi_msg_parser #(
  parameter int BYTE_TIMEOUT = 3_200_000
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] byte_in,
  input  logic       byte_valid_in,
  output logic [7:0] midi_velocity_out,
  output logic [7:0] midi_received_note_out,
  output logic [3:0] midi_channel_out,
  output logic       midi_status_out,
  output logic       midi_data_ready_out,
  output logic       parse_error_out
);

  localparam int CW = (BYTE_TIMEOUT > 1) ? $clog2(BYTE_TIMEOUT) : 1;
  localparam logic [CW-1:0] TMAX = CW'(BYTE_TIMEOUT - 1);

  typedef enum logic [2:0] {
    WAIT_STATUS,
    WAIT_NOTE,
    WAIT_VEL,
    SKIP,
    SYSEX
  } state_t;

  state_t          r_state, w_state;
  logic            r_rsValid, w_rsValid;
  logic            r_rsOn, w_rsOn;
  logic [3:0]      r_rsChan, w_rsChan;
  logic [6:0]      r_note, w_note;
  logic [1:0]      r_skip, w_skip;
  logic [CW-1:0]   r_cnt, w_cnt;
  logic [6:0]      r_vel, w_vel;
  logic [6:0]      r_noteOut, w_noteOut;
  logic [3:0]      r_chan, w_chan;
  logic            r_status, w_status;
  logic            r_ready, w_ready;
  logic            r_error, w_error;

  logic w_isRt, w_byte, w_isStatus, w_isData, w_active;

  // Real-time bytes are invisible to the parser, so they never count as traffic.
  assign w_isRt     = byte_valid_in && (byte_in >= 8'hF8);
  assign w_byte     = byte_valid_in && !w_isRt;
  assign w_isStatus = w_byte && byte_in[7];
  assign w_isData   = w_byte && !byte_in[7];
  assign w_active   = (r_state == WAIT_NOTE) || (r_state == WAIT_VEL) || (r_state == SKIP);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state   <= WAIT_STATUS;
      r_rsValid <= 1'b0;
      r_rsOn    <= 1'b0;
      r_rsChan  <= '0;
      r_note    <= '0;
      r_skip    <= '0;
      r_cnt     <= '0;
      r_vel     <= '0;
      r_noteOut <= '0;
      r_chan    <= '0;
      r_status  <= 1'b0;
      r_ready   <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_rsValid <= w_rsValid;
      r_rsOn    <= w_rsOn;
      r_rsChan  <= w_rsChan;
      r_note    <= w_note;
      r_skip    <= w_skip;
      r_cnt     <= w_cnt;
      r_vel     <= w_vel;
      r_noteOut <= w_noteOut;
      r_chan    <= w_chan;
      r_status  <= w_status;
      r_ready   <= w_ready;
      r_error   <= w_error;
    end
  end

  always_comb begin
    w_state   = r_state;
    w_rsValid = r_rsValid;
    w_rsOn    = r_rsOn;
    w_rsChan  = r_rsChan;
    w_note    = r_note;
    w_skip    = r_skip;
    w_cnt     = r_cnt;
    w_vel     = r_vel;
    w_noteOut = r_noteOut;
    w_chan    = r_chan;
    w_status  = r_status;
    w_ready   = 1'b0;
    w_error   = 1'b0;

    // Timeout only ages on truly idle cycles; the counter stops at TMAX because that exits.
    if (w_byte) begin
      w_cnt = '0;
    end else if (w_active && !w_isRt) begin
      if (r_cnt == TMAX) begin
        w_state = WAIT_STATUS;
        w_error = 1'b1;
        w_cnt   = '0;
      end else begin
        w_cnt = r_cnt + 1'b1;
      end
    end

    // A status byte always restarts decoding from scratch, whatever state we were in.
    if (w_isStatus) begin
      if (w_active) w_error = 1'b1;
      case (byte_in[7:4])
        4'h8, 4'h9: begin
          w_rsValid = 1'b1;
          w_rsOn    = byte_in[4];
          w_rsChan  = byte_in[3:0];
          w_state   = WAIT_NOTE;
        end
        4'hA, 4'hB, 4'hE: begin
          w_rsValid = 1'b0;
          w_state   = SKIP;
          w_skip    = 2'd2;
        end
        4'hC, 4'hD: begin
          w_rsValid = 1'b0;
          w_state   = SKIP;
          w_skip    = 2'd1;
        end
        default: begin
          w_rsValid = 1'b0;
          case (byte_in[3:0])
            4'h0:       w_state = SYSEX;
            4'h1, 4'h3: begin w_state = SKIP; w_skip = 2'd1; end
            4'h2:       begin w_state = SKIP; w_skip = 2'd2; end
            default:    w_state = WAIT_STATUS;
          endcase
        end
      endcase
    end else if (w_isData) begin
      case (r_state)
        WAIT_STATUS: begin
          if (r_rsValid) begin
            w_note  = byte_in[6:0];
            w_state = WAIT_VEL;
          end
        end
        WAIT_NOTE: begin
          w_note  = byte_in[6:0];
          w_state = WAIT_VEL;
        end
        WAIT_VEL: begin
          w_vel     = byte_in[6:0];
          w_noteOut = r_note;
          w_chan    = r_rsChan;
`ifdef MIDI_VEL0_NOTEOFF_EN
          w_status  = r_rsOn && (byte_in[6:0] != 7'd0);
`else
          w_status  = r_rsOn;
`endif
          w_ready   = 1'b1;
          w_state   = WAIT_STATUS;
        end
        SKIP: begin
          w_skip = r_skip - 2'd1;
          if (r_skip <= 2'd1) w_state = WAIT_STATUS;
        end
        SYSEX:   w_state = SYSEX;
        default: w_state = WAIT_STATUS;
      endcase
    end
  end

  assign midi_velocity_out      = {1'b0, r_vel};
  assign midi_received_note_out = {1'b0, r_noteOut};
  assign midi_channel_out       = r_chan;
  assign midi_status_out        = r_status;
  assign midi_data_ready_out    = r_ready;
  assign parse_error_out        = r_error;

endmodule

// File: tb/tb_midi_msg_parser.sv
// Bench for midi_msg_parser: directed test-plan sequences, then random byte traffic,
// every cycle compared against a message-level reference model.
module tb_midi_msg_parser;

  localparam int TO = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] byteIn = 8'h00;
  logic       byteValid = 1'b0;
  logic [7:0] velOut, noteOut;
  logic [3:0] chanOut;
  logic       statusOut, readyOut, errorOut;

  always #5 clk = ~clk;

  midi_msg_parser #(.BYTE_TIMEOUT(TO)) dut (
    .clk_in                 (clk),
    .rst_in                 (rst),
    .byte_in                (byteIn),
    .byte_valid_in          (byteValid),
    .midi_velocity_out      (velOut),
    .midi_received_note_out (noteOut),
    .midi_channel_out       (chanOut),
    .midi_status_out        (statusOut),
    .midi_data_ready_out    (readyOut),
    .parse_error_out        (errorOut)
  );

  int nChecks = 0;
  int nFails  = 0;
  int nReady  = 0;
  int nErr    = 0;

  // Message-level model: how many data bytes the current message still needs.
  int         mNeed;
  bit         mSysex, mNoteMsg, mRsV, mRsOn;
  logic [3:0] mRsCh;
  logic [6:0] mNote;
  int         mIdle;
  logic [7:0] eVel, eNote;
  logic [3:0] eCh;
  logic       eSt, eRdy, eErr;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    mNeed = 0; mSysex = 0; mNoteMsg = 0; mRsV = 0; mRsOn = 0; mRsCh = 0;
    mNote = 0; mIdle = 0;
    eVel = 0; eNote = 0; eCh = 0; eSt = 0; eRdy = 0; eErr = 0;
  endtask

  task automatic modelStep(input logic r, input logic v, input logic [7:0] b);
    eRdy = 0;
    eErr = 0;
    if (r) begin
      modelReset();
      return;
    end
    if (!v) begin
      if (mNeed > 0) begin
        mIdle++;
        if (mIdle == TO) begin
          eErr = 1; mNeed = 0; mIdle = 0;
        end
      end
      return;
    end
    if (b >= 8'hF8) return;
    mIdle = 0;
    if (b[7]) begin
      if (mNeed > 0) eErr = 1;
      mNeed = 0; mSysex = 0; mNoteMsg = 0;
      if (b[7:4] == 4'h8 || b[7:4] == 4'h9) begin
        mRsV = 1; mRsOn = (b[7:4] == 4'h9); mRsCh = b[3:0];
        mNeed = 2; mNoteMsg = 1;
      end else begin
        mRsV = 0;
        if (b[7:4] == 4'hA || b[7:4] == 4'hB || b[7:4] == 4'hE) mNeed = 2;
        else if (b[7:4] == 4'hC || b[7:4] == 4'hD) mNeed = 1;
        else if (b == 8'hF0) mSysex = 1;
        else if (b == 8'hF1 || b == 8'hF3) mNeed = 1;
        else if (b == 8'hF2) mNeed = 2;
      end
    end else if (mSysex) begin
      // SysEx payload is swallowed
    end else if (mNeed > 0) begin
      if (mNoteMsg && mNeed == 2) begin
        mNote = b[6:0]; mNeed = 1;
      end else if (mNoteMsg) begin
        eRdy = 1; eVel = b; eNote = {1'b0, mNote}; eCh = mRsCh;
`ifdef MIDI_VEL0_NOTEOFF_EN
        eSt = mRsOn && (b != 8'h00);
`else
        eSt = mRsOn;
`endif
        mNeed = 0;
      end else begin
        mNeed--;
      end
    end else if (mRsV) begin
      mNoteMsg = 1; mNote = b[6:0]; mNeed = 1;
    end
  endtask

  task automatic applyStimulus(input logic r, input logic v, input logic [7:0] b);
    @(negedge clk);
    rst = r; byteValid = v; byteIn = b;
    @(posedge clk);
    modelStep(r, v, b);
    #1;
    if (readyOut === 1'b1) nReady++;
    if (errorOut === 1'b1) nErr++;
    checkOutput("ready", readyOut, eRdy);
    checkOutput("error", errorOut, eErr);
    checkOutput("velocity", velOut, eVel);
    checkOutput("note", noteOut, eNote);
    checkOutput("channel", chanOut, eCh);
    checkOutput("status", statusOut, eSt);
  endtask

  task automatic sendByte(input logic [7:0] b);
    applyStimulus(1'b0, 1'b1, b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 8'h00);
  endtask

  int baseR, baseE;
  logic [7:0] rb;
  int cat;

  initial begin
    modelReset();
    applyStimulus(1'b1, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("reset note", noteOut, 8'h00);
    checkOutput("reset ready", readyOut, 1'b0);
    idle(2);

    // Single Note On
    baseR = nReady;
    sendByte(8'h93); sendByte(8'h3C); sendByte(8'h64);
    checkOutput("s1 strobe", readyOut, 1'b1);
    idle(3);
    checkOutput("s1 pulses", nReady - baseR, 1);
    checkOutput("s1 note hold", noteOut, 8'h3C);
    checkOutput("s1 vel hold", velOut, 8'h64);
    checkOutput("s1 ch hold", chanOut, 4'd3);
    checkOutput("s1 status hold", statusOut, 1'b1);

    // Running status including velocity 0
    baseR = nReady;
    sendByte(8'h90); sendByte(8'h40); sendByte(8'h50);
    sendByte(8'h43); sendByte(8'h50);
    sendByte(8'h40); sendByte(8'h00);
`ifdef MIDI_VEL0_NOTEOFF_EN
    checkOutput("s2 vel0 status", statusOut, 1'b0);
`else
    checkOutput("s2 vel0 status", statusOut, 1'b1);
`endif
    checkOutput("s2 vel0 vel", velOut, 8'h00);
    idle(2);
    checkOutput("s2 pulses", nReady - baseR, 3);

    // Real-time byte inside a running-status message
    baseR = nReady; baseE = nErr;
    sendByte(8'h91); sendByte(8'h45); sendByte(8'hF8); sendByte(8'h30);
    idle(2);
    checkOutput("s3 pulses", nReady - baseR, 1);
    checkOutput("s3 errors", nErr - baseE, 0);
    checkOutput("s3 note", noteOut, 8'h45);
    checkOutput("s3 ch", chanOut, 4'd1);

    // Control change and SysEx clear running status
    baseR = nReady;
    sendByte(8'hB0); sendByte(8'h07); sendByte(8'h7F);
    sendByte(8'hF0); sendByte(8'h41); sendByte(8'h10); sendByte(8'hF7);
    sendByte(8'h40); sendByte(8'h20);
    idle(2);
    checkOutput("s4 pulses", nReady - baseR, 0);

    // Timeout keeps running status
    baseR = nReady; baseE = nErr;
    sendByte(8'h92); sendByte(8'h3C);
    idle(TO + 5);
    checkOutput("s5 timeout errors", nErr - baseE, 1);
    sendByte(8'h50); sendByte(8'h22);
    idle(1);
    checkOutput("s5 pulses", nReady - baseR, 1);
    checkOutput("s5 note", noteOut, 8'h50);
    checkOutput("s5 ch", chanOut, 4'd2);

    // Status byte in the middle of a message
    baseR = nReady; baseE = nErr;
    sendByte(8'h90); sendByte(8'h3C); sendByte(8'h80);
    checkOutput("s6 error strobe", errorOut, 1'b1);
    sendByte(8'h3C); sendByte(8'h00);
    idle(2);
    checkOutput("s6 errors", nErr - baseE, 1);
    checkOutput("s6 pulses", nReady - baseR, 1);
    checkOutput("s6 status", statusOut, 1'b0);
    checkOutput("s6 note", noteOut, 8'h3C);

    // Reset mid-message
    baseR = nReady;
    sendByte(8'h90);
    applyStimulus(1'b1, 1'b0, 8'h00);
    sendByte(8'h3C); sendByte(8'h40);
    idle(2);
    checkOutput("s7 pulses", nReady - baseR, 0);
    checkOutput("s7 note", noteOut, 8'h00);
    checkOutput("s7 vel", velOut, 8'h00);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cat = int'($urandom_range(0, 9));
      case (cat)
        0, 1, 2, 3, 4: rb = 8'($urandom_range(0, 127));
        5, 6:          rb = 8'($urandom_range(8'h80, 8'h9F));
        7:             rb = 8'($urandom_range(8'hA0, 8'hF7));
        8:             rb = 8'($urandom_range(8'hF8, 8'hFF));
        default:       rb = ($urandom_range(0, 1) == 0) ? 8'hF0 : 8'hF7;
      endcase
      if ($urandom_range(0, 199) == 0) idle(TO + 2);
      applyStimulus(($urandom_range(0, 499) == 0), ($urandom_range(0, 3) != 0), rb);
    end
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/midi_msg_parser.md
Name: midi_msg_parser

Overview:
- Byte-level MIDI message decoder between the MIDI UART receiver and the note-burst collector.
- Consumes raw received bytes and emits one decoded Note On / Note Off event per complete message: note, velocity, channel, on/off flag and a one-cycle ready strobe.
- Handles running status and skips every non-note message.
- Ignores real-time bytes and SysEx, and aborts stalled messages on a timeout.

Parameters:
- BYTE_TIMEOUT, 3_200_000: cycles allowed between data bytes of one message before it is abandoned (about 32 ms at 100 MHz).

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- byte_in  input  8  received UART byte
- byte_valid_in  input  1  one-cycle strobe; byte_in is valid this cycle
- midi_velocity_out  output  8  velocity of the last event (bit 7 = 0)
- midi_received_note_out  output  8  note number of the last event (bit 7 = 0)
- midi_channel_out  output  4  channel of the last event
- midi_status_out  output  1  1 = Note On, 0 = Note Off
- midi_data_ready_out  output  1  one-cycle pulse; event outputs are valid
- parse_error_out  output  1  one-cycle pulse on timeout abort or an unexpected status byte mid-message

Behaviour:
- Reset:
  - All outputs are 0.
  - State is WAIT_STATUS, running status is cleared, the timeout counter is 0.
- Byte classes:
  - Status byte: bit 7 = 1.
  - Data byte: bit 7 = 0.
- Real-time bytes (0xF8..0xFF), in any state:
  - Ignored completely.
  - State, running status and timeout counter are unchanged.
- WAIT_STATUS:
  - 0x8n or 0x9n: latch the type and channel as running status, go to WAIT_NOTE.
  - 0xAn, 0xBn, 0xEn: running status is cleared; go to SKIP with skip count 2.
  - 0xCn, 0xDn: running status is cleared; go to SKIP with skip count 1.
  - 0xF0: go to SYSEX, clear running status.
  - 0xF1 or 0xF3: SKIP 1. 0xF2: SKIP 2. Other 0xF4..0xF7: stay. All of these clear running status.
  - Data byte with a valid running status: treat it as the note byte, go to WAIT_VEL.
  - Data byte without running status: discard it.
- WAIT_NOTE:
  - Data byte: latch the note, go to WAIT_VEL.
- WAIT_VEL:
  - Data byte: the next cycle drives all event outputs and pulses midi_data_ready_out for exactly 1 cycle.
  - Latency: ready is high the cycle after byte_valid_in of the velocity byte.
  - Go to WAIT_STATUS; running status is retained.
- Note type:
  - 0x8n gives midi_status_out = 0.
  - 0x9n gives midi_status_out = 1, except for velocity 0 (see Optional Feature).
- Event outputs hold their value until the next event; only the ready strobe returns to 0.
- SKIP:
  - Each data byte decrements the skip count; at 0, return to WAIT_STATUS.
- SYSEX:
  - Stays until 0xF7 (go to WAIT_STATUS) or any other non-real-time status byte.
  - Another status byte is handled as in WAIT_STATUS in the same cycle.
- Status byte received in WAIT_NOTE, WAIT_VEL or SKIP:
  - Abandon the partial message and pulse parse_error_out.
  - Process the new byte as in WAIT_STATUS in the same cycle. There is no lost byte.
- Timeout:
  - The counter runs while in WAIT_NOTE, WAIT_VEL or SKIP, and resets on every non-real-time byte.
  - On reaching BYTE_TIMEOUT-1: go to WAIT_STATUS, pulse parse_error_out, keep running status.
  - The counter is $clog2(BYTE_TIMEOUT) bits and saturates; it never wraps.
- byte_valid_in on consecutive cycles is supported; each byte is consumed in one cycle, with no backpressure.
- Reset mid-message: the partial message is discarded and no ready pulse is issued.

Optional Feature:
- Macro: MIDI_VEL0_NOTEOFF_EN.
- Defined: a Note On (0x9n) with velocity 0 is reported as midi_status_out = 0 (Note Off), per MIDI convention.
- Undefined: it is reported as midi_status_out = 1 with midi_velocity_out = 0.

Test Plan:
- 0x93, 0x3C, 0x64 at the byte rate -> one ready pulse the cycle after 0x64; note = 0x3C, vel = 0x64, ch = 3, status = 1; outputs hold afterwards.
- 0x90, 0x40, 0x50 then 0x43, 0x50 then 0x40, 0x00 (running status) -> 3 pulses.
  - Third pulse is status 0 with MIDI_VEL0_NOTEOFF_EN defined, status 1 / vel 0 without it.
- 0x91, 0x45, 0xF8 inserted, then 0x30 -> exactly one pulse: note 0x45, vel 0x30, ch 1; no parse_error_out.
- 0xB0, 0x07, 0x7F, then 0xF0, 0x41, 0x10, 0xF7, then 0x40, 0x20 -> no pulses, because running status was cleared by 0xB0.
- Timeout and mid-message status:
  - 0x92, 0x3C, then idle for BYTE_TIMEOUT cycles -> parse_error_out pulses once, state returns to WAIT_STATUS.
  - Then 0x50, 0x22 -> a running-status event: note 0x50, ch 2.
  - 0x90, 0x3C, 0x80, 0x3C, 0x00 -> parse_error_out on 0x80, then one pulse with status 0, note 0x3C.
- Reset: assert rst_in between 0x90 and 0x3C, then send 0x3C, 0x40 -> no pulse, all outputs stay 0.
